// File: rtl/rotate_kick.sv
// rtl/rotate_kick.sv - multi-cycle piece rotation with collision check and wall kicks
package rotate_kick_pkg;
    localparam int COORD_W = 6;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } coord_t;

    // data[r][i] is row i of rotation r; bit [3-j] is column j
    typedef struct packed {
        logic [3:0][3:0][3:0] data;
    } tetromino_t;

    typedef struct packed {
        logic [2:0]  idx;
        logic [1:0]  rotation;
        coord_t      coordinate;
        tetromino_t  tetromino;
    } tetromino_ctrl;
endpackage

module rotate_kick
    import rotate_kick_pkg::*;
#(
    parameter int BOARD_W   = 10,
    parameter int BOARD_H   = 20,
    parameter int NUM_KICKS = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       dir,
    input  tetromino_ctrl              t_in,
    input  logic [BOARD_W*BOARD_H-1:0] board_occ,
    output tetromino_ctrl              t_out,
    output logic                       success,
    output logic                       done,
    output logic                       busy,
    output logic [2:0]                 kick_idx
);
    localparam int OCC_AW = $clog2(BOARD_W * BOARD_H);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    k_q, k_d;
    tetromino_ctrl piece_q, piece_d;
    logic          dir_q, dir_d;
    tetromino_ctrl t_out_q, t_out_d;
    logic          success_q, success_d;
    logic [2:0]    kick_idx_q, kick_idx_d;

    logic [1:0]        target_rot;
    int                dx, dy, cand_x, cand_y, xi, yi;
    logic [3:0]        row;
    logic [OCC_AW-1:0] cell_a;
    logic              collide;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            piece_q    <= '0;
            dir_q      <= 1'b0;
            t_out_q    <= '0;
            success_q  <= 1'b0;
            kick_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            piece_q    <= piece_d;
            dir_q      <= dir_d;
            t_out_q    <= t_out_d;
            success_q  <= success_d;
            kick_idx_q <= kick_idx_d;
        end
    end

    // Candidate placement and full 4x4 collision test, evaluated in one cycle
    always_comb begin
        dx = 0;
        dy = 0;
        case (k_q)
            3'd1:    dx = -1;
            3'd2:    dx = 1;
            3'd3:    dy = -1;
            3'd4:    dx = -2;
            3'd5:    dx = 2;
            default: dx = 0;
        endcase
        target_rot = dir_q ? piece_q.rotation + 2'd3 : piece_q.rotation + 2'd1;
        cand_x  = int'(piece_q.coordinate.x) + dx;
        cand_y  = int'(piece_q.coordinate.y) + dy;
        collide = 1'b0;
        xi      = 0;
        yi      = 0;
        row     = '0;
        cell_a  = '0;
        for (int i = 0; i < 4; i++) begin
            row = piece_q.tetromino.data[target_rot][i[1:0]];
            for (int j = 0; j < 4; j++) begin
                if (row[2'(3 - j)]) begin
                    xi = cand_x + j;
                    yi = cand_y + i;
                    if (xi < 0 || xi >= BOARD_W || yi >= BOARD_H) begin
                        collide = 1'b1;
                    end else if (yi >= 0) begin
                        cell_a = OCC_AW'(yi * BOARD_W + xi);
                        if (board_occ[cell_a]) collide = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        piece_d    = piece_q;
        dir_d      = dir_q;
        t_out_d    = t_out_q;
        success_d  = success_q;
        kick_idx_d = kick_idx_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    piece_d = t_in;
                    dir_d   = dir;
                    k_d     = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!collide) begin
                    t_out_d                = piece_q;
                    t_out_d.rotation       = target_rot;
                    t_out_d.coordinate.x   = COORD_W'(cand_x);
                    t_out_d.coordinate.y   = COORD_W'(cand_y);
                    success_d              = 1'b1;
                    kick_idx_d             = k_q;
                    state_d                = DONE;
                end else if (k_q == 3'(NUM_KICKS - 1)) begin
                    t_out_d    = piece_q;
                    success_d  = 1'b0;
                    kick_idx_d = '0;
                    state_d    = DONE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign t_out    = t_out_q;
    assign success  = success_q;
    assign kick_idx = kick_idx_q;
    assign done     = (state_q == DONE);
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_rotate_kick.sv
// tb/tb_rotate_kick.sv - directed self-checking bench for rotate_kick
module tb_rotate_kick;
    import rotate_kick_pkg::*;

    localparam int W   = 10;
    localparam int H   = 20;
    localparam int OCC = W * H;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           dir;
    tetromino_ctrl  t_in;
    logic [OCC-1:0] board_occ;
    tetromino_ctrl  t_out;
    logic           success, done, busy;
    logic [2:0]     kick_idx;

    int vectors = 0;
    int errors  = 0;

    rotate_kick #(.BOARD_W(W), .BOARD_H(H), .NUM_KICKS(5)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir), .t_in(t_in),
        .board_occ(board_occ), .t_out(t_out), .success(success), .done(done),
        .busy(busy), .kick_idx(kick_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // idx 1 = I, idx 3 = T; row i of rotation r lives in data[r][i]
    function automatic tetromino_ctrl mk(input logic [2:0] idx, input logic [1:0] rot,
                                         input int x, input int y);
        tetromino_ctrl p;
        p = '0;
        p.idx = idx;
        p.rotation = rot;
        p.coordinate.x = COORD_W'(x);
        p.coordinate.y = COORD_W'(y);
        if (idx == 3'd3) begin
            p.tetromino.data[0][0] = 4'b0100; p.tetromino.data[0][1] = 4'b1110;
            p.tetromino.data[1][0] = 4'b0100; p.tetromino.data[1][1] = 4'b0110;
            p.tetromino.data[1][2] = 4'b0100;
            p.tetromino.data[2][1] = 4'b1110; p.tetromino.data[2][2] = 4'b0100;
            p.tetromino.data[3][0] = 4'b0100; p.tetromino.data[3][1] = 4'b1100;
            p.tetromino.data[3][2] = 4'b0100;
        end else begin
            p.tetromino.data[0][1] = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                p.tetromino.data[1][i] = 4'b0010;
                p.tetromino.data[3][i] = 4'b0100;
            end
            p.tetromino.data[2][2] = 4'b1111;
        end
        return p;
    endfunction

    function automatic tetromino_ctrl moved(input tetromino_ctrl p, input logic [1:0] rot,
                                            input int x, input int y);
        tetromino_ctrl q;
        q = p;
        q.rotation = rot;
        q.coordinate.x = COORD_W'(x);
        q.coordinate.y = COORD_W'(y);
        return q;
    endfunction

    // Issues one request; n = edges after E0 until done is seen, bcnt = busy samples
    task automatic run_op(input tetromino_ctrl p, input logic d, input logic [OCC-1:0] occ,
                          output int n, output int bcnt);
        t_in = p; dir = d; board_occ = occ; enable = 1'b1;
        tick();
        enable = 1'b0;
        n = 0;
        bcnt = busy ? 1 : 0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; dir = 1'b0; t_in = '0; board_occ = '0;
        tick(); tick();
        vectors++; if (t_out !== '0) begin errors++; $display("FAIL reset_t_out: got %h want 0", t_out); end
        vectors++; if (success !== 1'b0) begin errors++; $display("FAIL reset_success: got %b want 0", success); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (kick_idx !== 3'd0) begin errors++; $display("FAIL reset_kick_idx: got %0d want 0", kick_idx); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rotation();
        tetromino_ctrl p;
        int n, b;
        logic [1:0] start_rot [3] = '{2'd0, 2'd0, 2'd3};
        logic       dirs      [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0] want_rot  [3] = '{2'd1, 2'd3, 2'd0};
        for (int t = 0; t < 3; t++) begin
            p = mk(3'd3, start_rot[t], 4, 5);
            run_op(p, dirs[t], '0, n, b);
            vectors++; if (n !== 1) begin errors++; $display("FAIL rot%0d_latency: got %0d want 1", t, n); end
            vectors++; if (success !== 1'b1) begin errors++; $display("FAIL rot%0d_success: got %b want 1", t, success); end
            vectors++; if (kick_idx !== 3'd0) begin errors++; $display("FAIL rot%0d_kick: got %0d want 0", t, kick_idx); end
            vectors++;
            if (t_out !== moved(p, want_rot[t], 4, 5)) begin
                errors++; $display("FAIL rot%0d_t_out: got %h want %h", t, t_out, moved(p, want_rot[t], 4, 5));
            end
            tick();
            vectors++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rot%0d_end: got done=%b busy=%b want 0 0", t, done, busy); end
        end
    endtask

    task automatic test_wall_kick();
        tetromino_ctrl p;
        int n, b;
        p = mk(3'd1, 2'd1, 7, 5);
        run_op(p, 1'b0, '0, n, b);
        vectors++; if (n !== 2) begin errors++; $display("FAIL wall_latency: got %0d want 2", n); end
        vectors++; if (success !== 1'b1) begin errors++; $display("FAIL wall_success: got %b want 1", success); end
        vectors++; if (kick_idx !== 3'd1) begin errors++; $display("FAIL wall_kick: got %0d want 1", kick_idx); end
        vectors++; if (t_out !== moved(p, 2'd2, 6, 5)) begin errors++; $display("FAIL wall_t_out: got %h want %h", t_out, moved(p, 2'd2, 6, 5)); end
        tick();
    endtask

    task automatic test_floor_kick();
        tetromino_ctrl p;
        int n, b;
        p = mk(3'd3, 2'd0, 4, 18);
        run_op(p, 1'b0, '0, n, b);
        vectors++; if (n !== 4) begin errors++; $display("FAIL floor_latency: got %0d want 4", n); end
        vectors++; if (kick_idx !== 3'd3) begin errors++; $display("FAIL floor_kick: got %0d want 3", kick_idx); end
        vectors++; if (t_out !== moved(p, 2'd1, 4, 17)) begin errors++; $display("FAIL floor_t_out: got %h want %h", t_out, moved(p, 2'd1, 4, 17)); end
        tick();
    endtask

    task automatic test_spawn_zone();
        tetromino_ctrl p;
        int n, b;
        p = mk(3'd3, 2'd0, 4, -3);
        run_op(p, 1'b0, '1, n, b);
        vectors++; if (n !== 1 || success !== 1'b1) begin errors++; $display("FAIL spawn_accept: got n=%0d success=%b want 1 1", n, success); end
        vectors++; if (t_out !== moved(p, 2'd1, 4, -3)) begin errors++; $display("FAIL spawn_t_out: got %h want %h", t_out, moved(p, 2'd1, 4, -3)); end
        tick();
    endtask

    task automatic test_all_fail();
        tetromino_ctrl p;
        int n, b;
        p = mk(3'd3, 2'd0, 4, 5);
        run_op(p, 1'b0, '1, n, b);
        vectors++; if (n !== 5) begin errors++; $display("FAIL fail_latency: got %0d want 5", n); end
        vectors++; if (success !== 1'b0) begin errors++; $display("FAIL fail_success: got %b want 0", success); end
        vectors++; if (kick_idx !== 3'd0) begin errors++; $display("FAIL fail_kick: got %0d want 0", kick_idx); end
        vectors++; if (t_out !== p) begin errors++; $display("FAIL fail_t_out: got %h want %h", t_out, p); end
        vectors++; if (b !== 6) begin errors++; $display("FAIL fail_busy_edges: got %0d want 6", b); end
        tick();
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL fail_end: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_enable_while_busy();
        tetromino_ctrl p;
        int dones;
        p = mk(3'd3, 2'd0, 3, 6);
        t_in = p; dir = 1'b0; board_occ = '1; enable = 1'b1;
        tick(); enable = 1'b0;
        tick();
        t_in = mk(3'd1, 2'd2, 1, 1); enable = 1'b1;
        tick(); enable = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) dones++;
        end
        vectors++; if (dones !== 1) begin errors++; $display("FAIL busy_enable_dones: got %0d want 1", dones); end
        vectors++; if (t_out !== p) begin errors++; $display("FAIL busy_enable_t_out: got %h want %h", t_out, p); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_enable_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_op();
        tetromino_ctrl p;
        int n, b, dones;
        p = mk(3'd3, 2'd0, 4, 5);
        run_op(p, 1'b1, '0, n, b);
        tick();
        t_in = p; dir = 1'b0; board_occ = '1; enable = 1'b1;
        tick(); enable = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        vectors++; if (t_out !== '0 || success !== 1'b0 || kick_idx !== 3'd0) begin
            errors++; $display("FAIL midrst_outputs: got t_out=%h success=%b kick=%0d want 0 0 0", t_out, success, kick_idx);
        end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_fsm: got busy=%b done=%b want 0 0", busy, done); end
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) dones++;
        end
        vectors++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
        run_op(p, 1'b0, '0, n, b);
        vectors++; if (n !== 1 || success !== 1'b1 || t_out !== moved(p, 2'd1, 4, 5)) begin
            errors++; $display("FAIL midrst_recover: got n=%0d success=%b t_out=%h want 1 1 %h", n, success, t_out, moved(p, 2'd1, 4, 5));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wall_kick();
        test_floor_kick();
        test_spawn_zone();
        test_all_fail();
        test_enable_while_busy();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
